// File: rtl/divider_iterative.sv
// ---------------------------------------------------------------------------
// divider_iterative
//
// Iterative unsigned restoring divider: one quotient bit per clock cycle,
// WIDTH iterations per division, using a single-cycle valid_in/valid_out
// pulse handshake.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   valid_in    in   one-cycle pulse: capture a/b and start (or restart)
//   a           in   WIDTH-bit unsigned dividend
//   b           in   WIDTH-bit unsigned divisor
//   busy        out  high while a division is in progress
//   valid_out   out  one-cycle pulse: q, r, div_by_zero are valid
//   q           out  quotient, held until the next result
//   r           out  remainder, held until the next result
//   div_by_zero out  set with valid_out when b was 0, held with q/r
// ---------------------------------------------------------------------------
module divider_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid_out,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  // The partial remainder never exceeds the divisor, so its top bit is
  // always zero; only the low WIDTH bits are stored.
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic             w_last;

  // One restoring step: shift in the next dividend bit and try a subtract.
  always_comb begin
    w_shift = {r_rem, r_quo[WIDTH-1]};
    w_trial = w_shift - {1'b0, r_div};
    if (w_trial[WIDTH] == 1'b0) begin
      w_rem_next = w_trial[WIDTH-1:0];
      w_quo_next = {r_quo[WIDTH-2:0], 1'b1};
    end else begin
      w_rem_next = w_shift[WIDTH-1:0];
      w_quo_next = {r_quo[WIDTH-2:0], 1'b0};
    end
    w_last = (r_cnt == CW'(WIDTH - 1));
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rem       <= {WIDTH{1'b0}};
      r_quo       <= {WIDTH{1'b0}};
      r_div       <= {WIDTH{1'b0}};
      r_cnt       <= {CW{1'b0}};
      busy        <= 1'b0;
      valid_out   <= 1'b0;
      q           <= {WIDTH{1'b0}};
      r           <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      // A new request always wins, including over a completion on this edge.
      if (valid_in) begin
        r_state <= S_RUN;
        r_rem   <= {WIDTH{1'b0}};
        r_quo   <= a;
        r_div   <= b;
        r_cnt   <= {CW{1'b0}};
        busy    <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_IDLE;
          end
          S_RUN: begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_state     <= S_IDLE;
              busy        <= 1'b0;
              valid_out   <= 1'b1;
              q           <= w_quo_next;
              r           <= w_rem_next;
              div_by_zero <= (r_div == {WIDTH{1'b0}});
            end else begin
              r_state <= S_RUN;
            end
          end
          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_divider_iterative.sv
// ---------------------------------------------------------------------------
// tb_divider_iterative
//
// Scoreboard bench: each accepted request pushes its expected result
// (computed with plain / and %) into a queue; a monitor pops and compares
// whenever valid_out is seen, including the capture-to-result latency.
// ---------------------------------------------------------------------------
module tb_divider_iterative;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_in = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         valid_out;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         div_by_zero;

  divider_iterative #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .a(a), .b(b),
    .busy(busy), .valid_out(valid_out), .q(q), .r(r),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    longint       t;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  logic prev_vo = 1'b0;

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: unsigned division; divide by zero yields all ones and a.
  function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, longint t);
    exp_t e;
    if (y == '0) begin
      e.q = '1;
      e.r = x;
      e.dbz = 1'b1;
    end else begin
      e.q = x / y;
      e.r = x % y;
      e.dbz = 1'b0;
    end
    e.t = t;
    return e;
  endfunction

  // Monitor: compare each result with the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (valid_out) begin
      if (prev_vo) begin
        total++;
        bad++;
        $display("FAIL valid_out_width: got 2+ cycles expected 1");
      end
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid_out: got q=%0h r=%0h expected none", q, r);
      end else begin
        e = sb.pop_front();
        check("q", q, e.q);
        check("r", r, e.r);
        check("div_by_zero", W'(div_by_zero), W'(e.dbz));
        check("busy_at_result", W'(busy), W'(1'b0));
        check("latency", W'($time - e.t), W'(330));
      end
    end
    prev_vo = valid_out;
  end

  // Drive one request at the current negedge; a restart drops the pending one.
  task automatic issue(logic [W-1:0] x, logic [W-1:0] y);
    if (busy && sb.size() > 0) void'(sb.pop_back());
    a = x;
    b = y;
    valid_in = 1'b1;
    sb.push_back(model(x, y, longint'($time)));
    @(negedge clk);
    valid_in = 1'b0;
    check("busy_after_capture", W'(busy), W'(1'b1));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL wait_idle_timeout: got busy=1 expected 0 within 60 cycles");
    end
  endtask

  task automatic run_one(logic [W-1:0] x, logic [W-1:0] y);
    @(negedge clk);
    issue(x, y);
    wait_idle();
  endtask

  initial begin
    logic [W-1:0] x;
    logic [W-1:0] y;

    // Reset state
    #12;
    check("rst_busy", W'(busy), W'(1'b0));
    check("rst_valid_out", W'(valid_out), W'(1'b0));
    check("rst_q", q, '0);
    check("rst_r", r, '0);
    check("rst_dbz", W'(div_by_zero), W'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    // 100 / 7, then outputs hold while idle
    run_one(32'd100, 32'd7);
    repeat (3) @(negedge clk);
    check("hold_q", q, 32'd14);
    check("hold_r", r, 32'd2);

    // Reset mid-run clears outputs asynchronously; no result afterwards
    @(negedge clk);
    issue(32'd100, 32'd7);
    repeat (4) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_busy", W'(busy), W'(1'b0));
    check("async_q", q, '0);
    check("async_r", r, '0);
    check("async_dbz", W'(div_by_zero), W'(1'b0));
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    // Boundary operands
    run_one(32'hFFFF_FFFF, 32'd1);
    run_one(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_one(32'd5, 32'd9);
    run_one(32'd0, 32'd3);
    run_one(32'd1234, 32'd0);
    @(negedge clk);
    issue(32'd10, 32'd3);
    check("q_held_during_run", q, 32'hFFFF_FFFF);
    check("dbz_held_during_run", W'(div_by_zero), W'(1'b1));
    wait_idle();

    // Restart mid-run: only the second division reports
    @(negedge clk);
    issue(32'd100, 32'd7);
    repeat (8) @(negedge clk);
    issue(32'd50, 32'd6);
    wait_idle();

    // Back-to-back: issue on the cycle valid_out is high
    @(negedge clk);
    issue(32'd77, 32'd5);
    wait_idle();
    issue(32'd1000, 32'd33);
    wait_idle();

    // Randomized traffic with occasional restarts and back-to-back starts
    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      case ($urandom % 4)
        0: y = $urandom;
        1: y = W'($urandom_range(1, 255));
        2: y = W'($urandom % 4);
        default: begin
          y = $urandom >> ($urandom % 32);
          x = x >> ($urandom % 16);
        end
      endcase
      issue(x, y);
      if ($urandom % 5 == 0) begin
        repeat ($urandom_range(1, 30)) @(negedge clk);
        x = $urandom;
        y = W'($urandom_range(0, 1000));
        issue(x, y);
      end
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", W'(sb.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
